// File: rtl/cdec_dp_param_if.sv
// Memory bus between the cdec datapath (master) and the memory (slave).
interface cdec_dp_param_if #(
    parameter int DW = 8
);
    logic [DW-1:0] adrs;      // memory address (MAR)
    logic [DW-1:0] data_in;   // read data from memory
    logic [DW-1:0] data_out;  // write data to memory (WDR)
    logic          mem_rd;    // read request, held until acknowledged
    logic          mem_wr;    // write request, held until acknowledged
    logic          mem_ack;   // completion strobe from memory

    modport master (
        output adrs, data_out, mem_rd, mem_wr,
        input  data_in, mem_ack
    );

    modport slave (
        input  adrs, data_out, mem_rd, mem_wr,
        output data_in, mem_ack
    );
endinterface

// File: rtl/cdec_dp_param.sv
// cdec_dp_param: microcoded datapath with a single XBUS, an ALU, NGPR general
// registers and a three-state memory handshake FSM. Register writes are frozen
// while a memory access is outstanding.
// Optional debug monitor: define CDEC_DBG_MON_EN to drive resdt_o from resad_i;
// otherwise resdt_o is tied to zero.
module cdec_dp_param #(
    parameter int DW   = 8,
    parameter int NGPR = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [16:0]     ctrl_i,
    cdec_dp_param_if.master mem_if,
    output logic            busy_o,
    output logic [DW-1:0]   i_o,
    output logic [2:0]      szcy_o,
    input  logic [7:0]      resad_i,
    output logic [DW-1:0]   resdt_o
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Microcode word fields
    logic [1:0] mmrw;
    logic       fwr;
    logic       rwr;
    logic [3:0] xdst;
    logic [4:0] aluop;
    logic [3:0] xsrc;
    assign {mmrw, fwr, rwr, xdst, aluop, xsrc} = ctrl_i;

    // Architectural registers
    logic [DW-1:0] pc_q, mar_q, wdr_q, t_q, ir_q, r_q, rdr_q;
    logic [4:0]    flg_q;                 // {0, S, Z, Cy, 0}
    logic [DW-1:0] g_q [NGPR];
    logic [NGPR-1:0] g_we;

    logic [DW-1:0] xbus;
    logic [DW:0]   alu_wide;              // {carry/borrow, result}
    logic [DW-1:0] alu_res;
    logic          alu_s, alu_z, alu_cy;
    logic          wr_en;                 // register writes allowed this cycle
    logic          rdr_ld;                // capture read data into RDR
    logic          mem_rd, mem_wr;

    assign mem_if.adrs     = mar_q;
    assign mem_if.data_out = wdr_q;
    assign mem_if.mem_rd   = mem_rd;
    assign mem_if.mem_wr   = mem_wr;
    assign i_o             = ir_q;
    assign szcy_o          = flg_q[3:1];

    // XBUS source select; unassigned codes float to all-ones
    always_comb begin
        xbus = '1;
        case (xsrc)
            4'd0:    xbus = pc_q;
            4'd1:    xbus = r_q;
            4'd2:    xbus = rdr_q;
            4'd3:    xbus = DW'(flg_q);
            default: ;
        endcase
        for (int k = 0; k < NGPR; k++) begin
            if (xsrc == 4'(8 + k)) begin
                xbus = g_q[k];
            end
        end
    end

    // ALU: one extra bit carries carry-out, borrow or the shifted-out bit
    always_comb begin
        alu_wide = {1'b0, xbus};
        case (aluop)
            5'd1:    alu_wide = {1'b0, xbus} + {1'b0, t_q};
            5'd2:    alu_wide = {1'b0, xbus} + {1'b0, t_q} + {{DW{1'b0}}, flg_q[1]};
            5'd3:    alu_wide = {1'b0, xbus} - {1'b0, t_q};
            5'd4:    alu_wide = {1'b0, xbus} - {1'b0, t_q} - {{DW{1'b0}}, flg_q[1]};
            5'd5:    alu_wide = {1'b0, xbus & t_q};
            5'd6:    alu_wide = {1'b0, xbus | t_q};
            5'd7:    alu_wide = {1'b0, xbus ^ t_q};
            5'd8:    alu_wide = {1'b0, ~xbus};
            5'd9:    alu_wide = {1'b0, xbus} + {{DW{1'b0}}, 1'b1};
            5'd10:   alu_wide = {1'b0, xbus} - {{DW{1'b0}}, 1'b1};
            5'd11:   alu_wide = {xbus, 1'b0};
            5'd12:   alu_wide = {xbus[0], 1'b0, xbus[DW-1:1]};
            default: alu_wide = {1'b0, xbus};
        endcase
        alu_res = alu_wide[DW-1:0];
        alu_cy  = alu_wide[DW];
        alu_s   = alu_res[DW-1];
        alu_z   = (alu_res == '0);
    end

    // Memory FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory FSM next state, request strobes, stall and write gating
    always_comb begin
        state_d = state_q;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        busy_o  = 1'b0;
        wr_en   = 1'b0;
        rdr_ld  = 1'b0;
        case (state_q)
            IDLE: begin
                wr_en = 1'b1;
                if (mmrw == 2'b10) begin
                    state_d = RD_WAIT;
                    busy_o  = 1'b1;
                end else if (mmrw == 2'b01) begin
                    state_d = WR_WAIT;
                    busy_o  = 1'b1;
                end
            end
            RD_WAIT: begin
                mem_rd = 1'b1;
                busy_o = ~mem_if.mem_ack;
                if (mem_if.mem_ack) begin
                    rdr_ld  = 1'b1;
                    state_d = IDLE;
                end
            end
            WR_WAIT: begin
                mem_wr = 1'b1;
                busy_o = ~mem_if.mem_ack;
                if (mem_if.mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One write strobe per general register
    generate
        for (genvar gi = 0; gi < NGPR; gi++) begin : g_dec
            assign g_we[gi] = wr_en && (xdst == 4'(8 + gi));
        end
    endgenerate

    // Datapath registers; every write samples the pre-edge XBUS value
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q  <= '0;
            mar_q <= '0;
            wdr_q <= '0;
            t_q   <= '0;
            ir_q  <= '0;
            r_q   <= '0;
            rdr_q <= '0;
            flg_q <= '0;
            for (int k = 0; k < NGPR; k++) begin
                g_q[k] <= '0;
            end
        end else begin
            if (wr_en) begin
                case (xdst)
                    4'd0:    pc_q  <= xbus;
                    4'd1:    mar_q <= xbus;
                    4'd2:    wdr_q <= xbus;
                    4'd3:    t_q   <= xbus;
                    4'd4:    ir_q  <= xbus;
                    default: ;
                endcase
                if (rwr) begin
                    r_q <= alu_res;
                end
                if (fwr) begin
                    flg_q <= {1'b0, alu_s, alu_z, alu_cy, 1'b0};
                end
            end
            for (int k = 0; k < NGPR; k++) begin
                if (g_we[k]) begin
                    g_q[k] <= xbus;
                end
            end
            if (rdr_ld) begin
                rdr_q <= mem_if.data_in;
            end
        end
    end

`ifdef CDEC_DBG_MON_EN
    // Debug monitor read mux
    always_comb begin
        resdt_o = '0;
        case (resad_i)
            8'h00:   resdt_o = pc_q;
            8'h01:   resdt_o = ir_q;
            8'h02:   resdt_o = t_q;
            8'h03:   resdt_o = r_q;
            8'h04:   resdt_o = mar_q;
            8'h05:   resdt_o = mem_if.data_in;
            8'h06:   resdt_o = rdr_q;
            8'h07:   resdt_o = wdr_q;
            8'h0D:   resdt_o = DW'(flg_q);
            8'h0E:   resdt_o = DW'(state_q);
            default: ;
        endcase
        for (int k = 0; k < NGPR; k++) begin
            if (resad_i == 8'(16 + k)) begin
                resdt_o = g_q[k];
            end
        end
    end
`else
    assign resdt_o = '0;
    logic unused_resad;
    assign unused_resad = ^resad_i;
`endif

endmodule

// File: tb/tb_cdec_dp_param.sv
// Testbench for cdec_dp_param: ALU vector table, hand-written memory/reset
// sequences, randomized run against a spec-level model, and a DW=12/NGPR=8
// instance for the wide-register corner case.
module tb_cdec_dp_param;
    localparam int DW   = 8;
    localparam int NGPR = 3;
    localparam int M    = 256;

    localparam int S_PC = 0, S_R = 1, S_RDR = 2, S_FLG = 3, S_G0 = 8;
    localparam int D_PC = 0, D_MAR = 1, D_WDR = 2, D_T = 3, D_I = 4, D_NONE = 7, D_G0 = 8;

`ifdef CDEC_DBG_MON_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [16:0]   ctrl  = '0;
    logic [16:0]   ctrl2 = '0;
    logic [7:0]    resad = '0;
    logic [7:0]    resad2 = '0;
    logic          busy, busy2;
    logic [DW-1:0] iw, resdt;
    logic [2:0]    szcy, szcy2;
    logic [11:0]   i2, resdt2;

    cdec_dp_param_if #(.DW(DW)) mif();
    cdec_dp_param_if #(.DW(12)) mif2();

    cdec_dp_param #(.DW(DW), .NGPR(NGPR)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .ctrl_i  (ctrl),
        .mem_if  (mif),
        .busy_o  (busy),
        .i_o     (iw),
        .szcy_o  (szcy),
        .resad_i (resad),
        .resdt_o (resdt)
    );

    cdec_dp_param #(.DW(12), .NGPR(8)) dut2 (
        .clk_i   (clk),
        .rst_i   (rst),
        .ctrl_i  (ctrl2),
        .mem_if  (mif2),
        .busy_o  (busy2),
        .i_o     (i2),
        .szcy_o  (szcy2),
        .resad_i (resad2),
        .resdt_o (resdt2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end else begin
            $display("ok   %s = %0h", nm, act);
        end
    endtask

    function automatic logic [16:0] mk(input int mm, input int f, input int r,
                                       input int d, input int a, input int s);
        logic [31:0] mm_v, f_v, r_v, d_v, a_v, s_v;
        mm_v = mm; f_v = f; r_v = r; d_v = d; a_v = a; s_v = s;
        return {mm_v[1:0], f_v[0], r_v[0], d_v[3:0], a_v[4:0], s_v[3:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- hand-test helpers ----------------
    task automatic load_rdr(input logic [DW-1:0] v);
        ctrl = mk(2, 0, 0, D_NONE, 0, 0);
        step();
        mif.mem_ack = 1'b1;
        mif.data_in = v;
        ctrl = mk(0, 0, 0, D_NONE, 0, 0);
        step();
        mif.mem_ack = 1'b0;
    endtask

    task automatic mov(input int s, input int d);
        ctrl = mk(0, 0, 0, d, 0, s);
        step();
        ctrl = mk(0, 0, 0, D_NONE, 0, 0);
    endtask

    task automatic peek(input int s, output logic [DW-1:0] v);
        mov(s, D_I);
        v = iw;
    endtask

    // ---------------- reference model ----------------
    int m_pc, m_r, m_rdr, m_mar, m_wdr, m_t, m_ir, m_s, m_z, m_c, pend;
    int m_g [NGPR];

    function automatic int flgv();
        return (m_s << 3) | (m_z << 2) | (m_c << 1);
    endfunction

    function automatic int srcv(input int s);
        case (s)
            0: return m_pc;
            1: return m_r;
            2: return m_rdr;
            3: return flgv();
            default: begin
                if (s >= 8 && s < 8 + NGPR) return m_g[s-8];
                return M - 1;
            end
        endcase
    endfunction

    function automatic void alu(input int op, input int x, input int t, input int ci,
                                output int res, output int co);
        int v;
        co = 0;
        case (op)
            1:  begin v = x + t;      res = v % M; co = (v >= M) ? 1 : 0; end
            2:  begin v = x + t + ci; res = v % M; co = (v >= M) ? 1 : 0; end
            3:  begin res = (x - t + M) % M;          co = (x < t) ? 1 : 0; end
            4:  begin res = (x - t - ci + 2 * M) % M; co = (x < t + ci) ? 1 : 0; end
            5:  res = x & t;
            6:  res = x | t;
            7:  res = x ^ t;
            8:  res = (M - 1) - x;
            9:  begin v = x + 1; res = v % M; co = (v >= M) ? 1 : 0; end
            10: begin res = (x + M - 1) % M; co = (x == 0) ? 1 : 0; end
            11: begin res = (x * 2) % M; co = (x >= M / 2) ? 1 : 0; end
            12: begin res = x / 2; co = x % 2; end
            default: res = x;
        endcase
    endfunction

    function automatic int dbg_model(input int ra, input int din);
        case (ra)
            'h00: return m_pc;
            'h01: return m_ir;
            'h02: return m_t;
            'h03: return m_r;
            'h04: return m_mar;
            'h05: return din;
            'h06: return m_rdr;
            'h07: return m_wdr;
            'h0D: return flgv();
            'h0E: return pend;   // 0 idle, 1 read pending, 2 write pending
            default: begin
                if (ra >= 16 && ra < 16 + NGPR) return m_g[ra-16];
                return 0;
            end
        endcase
    endfunction

    // One model-checked cycle on the main DUT
    task automatic cyc(input logic [16:0] c, input logic ack, input int din, input int ra);
        int mm, fw, rw, dst, op, src, x, res, co, exp_busy, exp_dbg;
        mm  = int'(c[16:15]);
        fw  = int'(c[14]);
        rw  = int'(c[13]);
        dst = int'(c[12:9]);
        op  = int'(c[8:4]);
        src = int'(c[3:0]);
        ctrl        = c;
        mif.mem_ack = ack;
        mif.data_in = din[DW-1:0];
        resad       = ra[7:0];
        #1;
        exp_busy = (pend == 0) ? ((mm == 1 || mm == 2) ? 1 : 0) : (ack ? 0 : 1);
        chk("busy", busy, exp_busy);
        chk("mem_rd", mif.mem_rd, (pend == 1) ? 1 : 0);
        chk("mem_wr", mif.mem_wr, (pend == 2) ? 1 : 0);
        exp_dbg = DBG_EN ? dbg_model(ra, din) : 0;
        chk("resdt", resdt, exp_dbg);
        @(posedge clk);
        #1;
        if (pend == 0) begin
            x = srcv(src);
            alu(op, x, m_t, m_c, res, co);
            case (dst)
                0: m_pc  = x;
                1: m_mar = x;
                2: m_wdr = x;
                3: m_t   = x;
                4: m_ir  = x;
                default: if (dst >= 8 && dst < 8 + NGPR) m_g[dst-8] = x;
            endcase
            if (rw != 0) m_r = res;
            if (fw != 0) begin
                m_s = (res >= M / 2) ? 1 : 0;
                m_z = (res == 0) ? 1 : 0;
                m_c = co;
            end
            pend = (mm == 2) ? 1 : ((mm == 1) ? 2 : 0);
        end else if (ack) begin
            if (pend == 1) m_rdr = din;
            pend = 0;
        end
        chk("I", iw, m_ir);
        chk("SZCy", szcy, flgv() >> 1);
        chk("adrs", mif.adrs, m_mar);
        chk("data_out", mif.data_out, m_wdr);
    endtask

    // ---------------- ALU vector table ----------------
    typedef struct {
        int            op;
        logic [7:0]    x;
        logic [7:0]    t;
        int            ci;
        logic [7:0]    r;
        logic [2:0]    f;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        int mm, ack, din, pick;

        tbl[0]  = '{1,  8'h7F, 8'h01, 0, 8'h80, 3'b100};
        tbl[1]  = '{3,  8'h00, 8'h01, 0, 8'hFF, 3'b101};
        tbl[2]  = '{10, 8'h00, 8'h00, 0, 8'hFF, 3'b101};
        tbl[3]  = '{2,  8'hFF, 8'h00, 1, 8'h00, 3'b011};
        tbl[4]  = '{4,  8'h05, 8'h03, 1, 8'h01, 3'b000};
        tbl[5]  = '{5,  8'hF0, 8'h3C, 0, 8'h30, 3'b000};
        tbl[6]  = '{6,  8'hF0, 8'h0F, 0, 8'hFF, 3'b100};
        tbl[7]  = '{7,  8'hAA, 8'hAA, 0, 8'h00, 3'b010};
        tbl[8]  = '{8,  8'h0F, 8'h00, 0, 8'hF0, 3'b100};
        tbl[9]  = '{9,  8'hFF, 8'h00, 0, 8'h00, 3'b011};
        tbl[10] = '{11, 8'h81, 8'h00, 0, 8'h02, 3'b001};
        tbl[11] = '{12, 8'h01, 8'h00, 0, 8'h00, 3'b011};
        tbl[12] = '{0,  8'h80, 8'h00, 0, 8'h80, 3'b100};
        tbl[13] = '{31, 8'h00, 8'h00, 0, 8'h00, 3'b010};
        tbl[14] = '{2,  8'h7F, 8'h00, 1, 8'h80, 3'b100};

        mif.mem_ack  = 1'b0;
        mif.data_in  = '0;
        mif2.mem_ack = 1'b0;
        mif2.data_in = '0;
        ctrl = mk(0, 0, 0, D_NONE, 0, 0);

        // Reset state
        step(); step();
        chk("rst_adrs", mif.adrs, 0);
        chk("rst_data_out", mif.data_out, 0);
        chk("rst_I", iw, 0);
        chk("rst_SZCy", szcy, 0);
        chk("rst_mem_rd", mif.mem_rd, 0);
        chk("rst_mem_wr", mif.mem_wr, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        // ALU vectors
        for (int i = 0; i < 15; i++) begin
            load_rdr((tbl[i].ci != 0) ? 8'h80 : 8'h00);
            ctrl = mk(0, 1, 0, D_NONE, 11, S_RDR);
            step();
            load_rdr(tbl[i].t);
            mov(S_RDR, D_T);
            load_rdr(tbl[i].x);
            mov(S_RDR, D_G0);
            ctrl = mk(0, 1, 1, D_NONE, tbl[i].op, S_G0);
            step();
            ctrl = mk(0, 0, 0, D_NONE, 0, 0);
            chk($sformatf("alu%0d_op%0d_SZCy", i, tbl[i].op), szcy, tbl[i].f);
            peek(S_R, v);
            chk($sformatf("alu%0d_op%0d_R", i, tbl[i].op), v, tbl[i].r);
        end

        // Read with three wait cycles; writes during waits are dropped
        load_rdr(8'h20);
        mov(S_RDR, D_MAR);
        chk("rd_mar", mif.adrs, 8'h20);
        ctrl = mk(2, 0, 0, D_NONE, 0, 0);
        #1;
        chk("rd_issue_busy", busy, 1);
        chk("rd_issue_mem_rd", mif.mem_rd, 0);
        step();
        for (int w = 0; w < 3; w++) begin
            ctrl = mk(0, 1, 1, D_MAR, 9, S_PC);
            #1;
            chk($sformatf("rd_wait%0d_mem_rd", w), mif.mem_rd, 1);
            chk($sformatf("rd_wait%0d_busy", w), busy, 1);
            step();
            chk($sformatf("rd_wait%0d_adrs", w), mif.adrs, 8'h20);
            chk($sformatf("rd_wait%0d_SZCy", w), szcy, tbl[14].f);
        end
        mif.mem_ack = 1'b1;
        mif.data_in = 8'hA5;
        ctrl = mk(0, 0, 0, D_NONE, 0, 0);
        #1;
        chk("rd_ack_busy", busy, 0);
        chk("rd_ack_mem_rd", mif.mem_rd, 1);
        step();
        mif.mem_ack = 1'b0;
        chk("rd_done_mem_rd", mif.mem_rd, 0);
        chk("rd_done_busy", busy, 0);
        peek(S_RDR, v);
        chk("rd_rdr", v, 8'hA5);

        // Write with immediate ack
        load_rdr(8'h3C);
        mov(S_RDR, D_WDR);
        chk("wr_wdr", mif.data_out, 8'h3C);
        ctrl = mk(1, 0, 0, D_NONE, 0, 0);
        #1;
        chk("wr_issue_busy", busy, 1);
        chk("wr_issue_mem_wr", mif.mem_wr, 0);
        step();
        ctrl = mk(0, 0, 0, D_NONE, 0, 0);
        chk("wr_mem_wr", mif.mem_wr, 1);
        chk("wr_adrs", mif.adrs, 8'h20);
        chk("wr_data_out", mif.data_out, 8'h3C);
        mif.mem_ack = 1'b1;
        #1;
        chk("wr_ack_busy", busy, 0);
        step();
        mif.mem_ack = 1'b0;
        chk("wr_done_mem_wr", mif.mem_wr, 0);
        chk("wr_done_busy", busy, 0);
        chk("wr_done_data_out", mif.data_out, 8'h3C);

        // mmrw=11 starts no access
        ctrl = mk(3, 0, 0, D_NONE, 0, 0);
        #1;
        chk("mm11_busy", busy, 0);
        step();
        ctrl = mk(0, 0, 0, D_NONE, 0, 0);
        chk("mm11_mem_rd", mif.mem_rd, 0);
        chk("mm11_mem_wr", mif.mem_wr, 0);

        // Reset during RD_WAIT aborts the access
        load_rdr(8'h55);
        mov(S_RDR, D_PC);
        ctrl = mk(2, 0, 0, D_NONE, 0, 0);
        step();
        ctrl = mk(0, 0, 0, D_NONE, 0, 0);
        chk("rstrd_mem_rd_before", mif.mem_rd, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstrd_mem_rd_async", mif.mem_rd, 0);
        mif.mem_ack = 1'b1;
        mif.data_in = 8'h77;
        step();
        step();
        rst = 1'b0;
        mif.mem_ack = 1'b0;
        chk("rstrd_busy", busy, 0);
        chk("rstrd_I", iw, 0);
        peek(S_RDR, v);
        chk("rstrd_rdr", v, 0);
        peek(S_PC, v);
        chk("rstrd_pc", v, 0);

        // Randomized run against the model
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_pc = 0; m_r = 0; m_rdr = 0; m_mar = 0; m_wdr = 0; m_t = 0; m_ir = 0;
        m_s = 0; m_z = 0; m_c = 0; pend = 0;
        for (int k = 0; k < NGPR; k++) m_g[k] = 0;
        for (int n = 0; n < 400; n++) begin
            if (pend == 0) begin
                pick = int'($urandom_range(0, 9));
                mm = (pick == 0) ? 2 : ((pick == 1) ? 1 : ((pick == 2) ? 3 : 0));
                ack = int'($urandom_range(0, 1));
            end else begin
                mm = int'($urandom_range(0, 3));
                ack = ($urandom_range(0, 2) == 0) ? 1 : 0;
            end
            din = int'($urandom_range(0, M - 1));
            cyc(mk(mm, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
                   $urandom_range(0, 31), $urandom_range(0, 15)),
                ack[0], din, int'($urandom_range(0, 31)));
        end
        cyc(mk(0, 0, 0, D_NONE, 0, 0), 1'b1, 0, 0);
        foreach (tbl[i]) begin
            if (i < 7) begin
                cyc(mk(0, 0, 0, D_I, 0, (i < 4) ? i : (S_G0 + i - 4)), 1'b0, 0, 16 + (i % 4));
            end
        end

        // DW=12, NGPR=8 instance: G7 all-ones, increment wraps
        ctrl2 = mk(2, 0, 0, 7, 0, 0);
        step();
        mif2.mem_ack = 1'b1;
        mif2.data_in = 12'hFFF;
        ctrl2 = mk(0, 0, 0, 15, 0, 2);
        step();
        mif2.mem_ack = 1'b0;
        step();
        ctrl2 = mk(0, 1, 1, 7, 9, 15);
        step();
        chk("w12_inc_SZCy", szcy2, 3'b011);
        resad2 = 8'h17;
        #1;
        chk("w12_resdt_g7", resdt2, DBG_EN ? 12'hFFF : 12'h000);
        ctrl2 = mk(0, 0, 0, 4, 0, 15);
        step();
        chk("w12_g7", i2, 12'hFFF);
        ctrl2 = mk(0, 0, 0, 4, 0, 1);
        step();
        chk("w12_R", i2, 12'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
